// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder that gathers a 4-lane bundle from word-wide memory
// Lanes below the start lane stay zero; a misaligned PC is answered at once with resp_err.
module imem_responder #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_pc,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ADDR_W-1:0]   resp_pc,
  output logic [4*INST_W-1:0] resp_inst,
  output logic [3:0]          resp_mask,
  output logic                resp_err,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INST_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] lane;
  logic [1:0] start_lane;
  logic [1:0] pend_lane;
  logic       pend;
  logic       accept;
  logic       misaligned;

  assign accept     = req_valid && req_ready;
  assign misaligned = (req_pc[1:0] != 2'b00);

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == IDLE) && !flush && rst_n;
    resp_valid = (state == RESP);
    mem_rd_en  = (state == READ) && !flush;
    mem_addr   = '0;
    if (mem_rd_en) mem_addr = {resp_pc[ADDR_W-1:4], lane, 2'b00};
    case (state)
      IDLE:  if (accept) state_nxt = misaligned ? RESP : READ;
      READ:  if (lane == 2'd3) state_nxt = DRAIN;
      DRAIN: state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= 2'd0;
      start_lane <= 2'd0;
      pend_lane  <= 2'd0;
      pend       <= 1'b0;
      resp_pc    <= '0;
      resp_inst  <= '0;
      resp_mask  <= 4'b0000;
      resp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // A read issued this cycle lands in its lane on the next edge.
      pend      <= mem_rd_en;
      pend_lane <= lane;
      if (flush) begin
        if (state != IDLE) begin
          resp_inst <= '0;
          resp_mask <= 4'b0000;
          resp_err  <= 1'b0;
        end
      end else begin
        if (pend) resp_inst[pend_lane*INST_W +: INST_W] <= mem_rdata;
        case (state)
          IDLE: begin
            if (accept) begin
              resp_pc    <= req_pc;
              lane       <= req_pc[3:2];
              start_lane <= req_pc[3:2];
              resp_inst  <= '0;
              resp_mask  <= 4'b0000;
              resp_err   <= misaligned;
            end
          end
          READ:    lane      <= lane + 2'd1;
          DRAIN:   resp_mask <= 4'b1111 << start_lane;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder against a fetch-level model
module tb_imem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_pc = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [31:0]  resp_pc;
  logic [127:0] resp_inst;
  logic [3:0]   resp_mask;
  logic         resp_err;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] seed;
  logic [31:0] rd_q[$];
  int          rd_cyc[$];

  imem_responder #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
    .resp_inst(resp_inst), .resp_mask(resp_mask), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // Memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem_rd_en ? mem_fn(mem_addr) : $urandom;
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_q.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
  end

  task automatic run_fetch(input logic [31:0] pc, input int hold);
    logic [1:0]   s;
    logic [1:0]   kk;
    bit           mis;
    int           exp_lat, lat, nrd;
    logic [3:0]   exp_mask;
    logic [127:0] exp_inst;
    logic [31:0]  exp_addr[$];
    s = pc[3:2];
    mis = (pc[1:0] != 2'b00);
    exp_lat = mis ? 1 : 6 - int'(s);
    exp_mask = mis ? 4'b0000 : (4'b1111 << s);
    exp_inst = '0;
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      if (!mis && k >= int'(s)) begin
        exp_inst[k*32 +: 32] = mem_fn({pc[31:4], kk, 2'b00});
        exp_addr.push_back({pc[31:4], kk, 2'b00});
      end
    end
    @(posedge clk); #1;
    req_pc = pc; req_valid = 1'b1; resp_ready = (hold == 0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle pc=%h got %b expected 1", pc, req_ready); end
    rd_q.delete(); rd_cyc.delete();
    @(posedge clk); #1;
    req_valid = 1'b0; req_pc = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency pc=%h got %0d expected %0d", pc, lat, exp_lat); end
    checks++; if (resp_pc !== pc) begin errors++; $display("FAIL resp_pc got %h expected %h", resp_pc, pc); end
    checks++; if (resp_inst !== exp_inst) begin errors++; $display("FAIL resp_inst pc=%h got %h expected %h", pc, resp_inst, exp_inst); end
    checks++; if (resp_mask !== exp_mask) begin errors++; $display("FAIL resp_mask pc=%h got %b expected %b", pc, resp_mask, exp_mask); end
    checks++; if (resp_err !== mis) begin errors++; $display("FAIL resp_err pc=%h got %b expected %b", pc, resp_err, mis); end
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_pc !== pc || resp_inst !== exp_inst ||
            resp_mask !== exp_mask || resp_err !== mis) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d got v=%b rdy=%b pc=%h m=%b e=%b expected v=1 rdy=0 pc=%h m=%b e=%b",
                   i, resp_valid, req_ready, resp_pc, resp_mask, resp_err, pc, exp_mask, mis);
        end
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL back_to_idle got v=%b rdy=%b expected v=0 rdy=1", resp_valid, req_ready); end
    nrd = exp_addr.size();
    checks++; if (rd_q.size() != nrd) begin errors++; $display("FAIL read_count pc=%h got %0d expected %0d", pc, rd_q.size(), nrd); end
    for (int i = 0; i < nrd && i < rd_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_addr[i]) begin errors++; $display("FAIL read_addr[%0d] got %h expected %h", i, rd_q[i], exp_addr[i]); end
      if (i > 0) begin
        checks++; if (rd_cyc[i] != rd_cyc[0] + i) begin errors++; $display("FAIL read_consecutive[%0d] got %0d expected %0d", i, rd_cyc[i], rd_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_pc = 32'h100;
    #3;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_rd_en !== 1'b0 ||
        resp_pc !== '0 || resp_inst !== '0 || resp_mask !== 4'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b e=%b rd=%b pc=%h m=%b a=%h expected all zero",
               req_ready, resp_valid, resp_err, mem_rd_en, resp_pc, resp_mask, mem_addr);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b v=%b expected rdy=1 v=0", req_ready, resp_valid); end
  endtask

  task automatic test_aligned;
    run_fetch(32'h0000_0100, 0);
  endtask

  task automatic test_mid_block;
    run_fetch(32'h0000_0208, 0);
    run_fetch(32'h0000_020C, 1);
  endtask

  task automatic test_backpressure;
    run_fetch(32'h0000_0400, 5);
  endtask

  task automatic test_misaligned;
    run_fetch(32'h0000_0102, 0);
    run_fetch(32'h0000_0ab1, 3);
  endtask

  task automatic test_random;
    logic [31:0] pc;
    for (int i = 0; i < 12; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      run_fetch(pc, $urandom_range(0, 3));
    end
  endtask

  task automatic test_flush;
    int bad_v, bad_rd;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h0000_0500;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_block got %b expected 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_noop got rdy=%b v=%b expected rdy=1 v=0", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h0000_0600;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_read_block got %b expected 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    rd_q.delete(); rd_cyc.delete();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b expected 1", req_ready); end
    bad_v = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad_v++;
    end
    checks++; if (bad_v != 0) begin errors++; $display("FAIL flush_no_resp got %0d valid cycles expected 0", bad_v); end
    bad_rd = rd_q.size();
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL flush_no_reads got %0d reads expected 0", bad_rd); end
    run_fetch(32'h0000_0500, 0);
  endtask

  task automatic test_flush_in_read;
    int bad_v;
    @(posedge clk); #1;
    req_valid = 1'b1; req_pc = 32'h0000_0800;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h0000_0900;
    @(negedge clk);
    checks++; if (mem_rd_en !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL flush_read2 got rd=%b rdy=%b expected rd=0 rdy=0", mem_rd_en, req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    rd_q.delete(); rd_cyc.delete();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_read_ready got %b expected 1", req_ready); end
    bad_v = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad_v++;
    end
    checks++; if (bad_v != 0 || rd_q.size() != 0) begin errors++; $display("FAIL flush_read_quiet got valid=%0d reads=%0d expected 0 0", bad_v, rd_q.size()); end
    run_fetch(32'h0000_0904, 0);
  endtask

  task automatic test_reset_in_resp;
    int lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_pc = 32'h0000_0700; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_reach got %b expected 1", resp_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_rd_en !== 1'b0 ||
        resp_pc !== '0 || resp_inst !== '0 || resp_mask !== 4'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL rst_resp_outputs got rdy=%b v=%b pc=%h m=%b expected all zero", req_ready, resp_valid, resp_pc, resp_mask);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale got %b expected 0", resp_valid); end
    run_fetch(32'h0000_0300, 0);
  endtask

  initial begin
    seed = $urandom;
    test_reset;
    test_aligned;
    test_mid_block;
    test_backpressure;
    test_misaligned;
    test_flush;
    test_flush_in_read;
    test_reset_in_resp;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
